lcd_burst_sched: RTL and testbench

LCD_BURST_SCHED -- requirements
Module: lcd_burst_sched

---
 rtl/lcd_burst_sched.sv | 110 +++++++++++
 tb/tb_lcd_burst_sched.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_burst_sched.sv
// lcd_burst_sched: splits a frame-buffer fetch into read bursts sized to the pixel FIFO's free room, one burst outstanding at a time.
// frame_start -> burst_req in 2 cycles; request held stable until burst_ack; optional LCD_BURST_SCHED_AUTO_RESTART_EN refetches the frame continuously.
module lcd_burst_sched #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned FRAME_WORDS = 384000,
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned FIFO_DEPTH  = 1024
) (
    input  logic        fifo_wr_clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [9:0]  fifo_wr_cnt,
    output logic        burst_req,
    output logic [31:0] burst_addr,
    output logic [7:0]  burst_len,
    input  logic        burst_ack,
    input  logic        burst_done,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_overrun
);
    typedef enum logic [2:0] {IDLE, CHECK, REQ, WAIT, DONE} state_t;

    localparam logic [23:0] FRAME_WORDS_W = 24'(FRAME_WORDS);
    localparam logic [23:0] BURST_LEN_W   = 24'(BURST_LEN);
    localparam logic [8:0]  BURST_LEN_9   = 9'(BURST_LEN);
    localparam logic [10:0] BURST_LEN_C   = 11'(BURST_LEN);
    localparam logic [10:0] FILL_LIMIT    = 11'(FIFO_DEPTH - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [23:0] remaining_q, remaining_d;
    logic        overrun_q, overrun_d;
    logic [8:0]  words;
    logic        fifo_has_room;

    // Words in the current burst: a full burst, or whatever is left at the frame tail.
    assign words         = (remaining_q < BURST_LEN_W) ? remaining_q[8:0] : BURST_LEN_9;
    assign fifo_has_room = (({1'b0, fifo_wr_cnt} + BURST_LEN_C) <= FILL_LIMIT);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        overrun_d   = overrun_q | (frame_start & (state_q != IDLE));
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    addr_d      = BASE_ADDR;
                    remaining_d = FRAME_WORDS_W;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (remaining_q == '0) begin
                    state_d = DONE;
                end else if (fifo_has_room) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (burst_ack) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (burst_done) begin
                    addr_d      = addr_q + {21'd0, words, 2'b00};
                    remaining_d = remaining_q - {15'd0, words};
                    state_d     = CHECK;
                end
            end
            DONE: begin
`ifdef LCD_BURST_SCHED_AUTO_RESTART_EN
                addr_d      = BASE_ADDR;
                remaining_d = FRAME_WORDS_W;
                state_d     = CHECK;
`else
                state_d     = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge fifo_wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            overrun_q   <= overrun_d;
        end
    end

    // Request fields read as zero outside REQ so reset and idle both present a clean bus.
    assign burst_req     = (state_q == REQ);
    assign burst_addr    = burst_req ? addr_q : 32'd0;
    assign burst_len     = burst_req ? 8'(words - 9'd1) : 8'd0;
    assign busy          = (state_q != IDLE);
    assign frame_done    = (state_q == DONE);
    assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_lcd_burst_sched.sv
// Randomized bench for lcd_burst_sched: reactive memory-master responder, frame-level reference model, directed corner cases.
module tb_lcd_burst_sched;
`ifdef LCD_BURST_SCHED_AUTO_RESTART_EN
    localparam int FW = 16;
`else
    localparam int FW = 40;
`endif
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          BL    = 16;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic [9:0]  fifo_wr_cnt;
    logic        burst_req;
    logic [31:0] burst_addr;
    logic [7:0]  burst_len;
    logic        burst_ack;
    logic        burst_done;
    logic        busy;
    logic        frame_done;
    logic        frame_overrun;

    always #5 clk = ~clk;

    lcd_burst_sched #(
        .BASE_ADDR(BASE), .FRAME_WORDS(FW), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH)
    ) dut (
        .fifo_wr_clk(clk), .rst_n(rst_n), .frame_start(frame_start), .fifo_wr_cnt(fifo_wr_cnt),
        .burst_req(burst_req), .burst_addr(burst_addr), .burst_len(burst_len),
        .burst_ack(burst_ack), .burst_done(burst_done), .busy(busy),
        .frame_done(frame_done), .frame_overrun(frame_overrun)
    );

    typedef struct {
        logic [31:0] a;
        logic [7:0]  l;
    } burst_t;

    int n_checks = 0;
    int n_fail = 0;
    int n_frame_done = 0;
    burst_t blog[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the frame is a precomputed list of bursts; progress is tracked per burst.
    burst_t bq[$];
    bit m_active = 0, m_checking = 0, m_req = 0, m_wait = 0, m_end = 0, m_ovr = 0;

    task automatic build_frame();
        bq.delete();
        for (int w = 0; w < FW; w += BL) begin
            burst_t b;
            int n;
            n = (FW - w < BL) ? FW - w : BL;
            b.a = BASE + 32'(4 * w);
            b.l = 8'(n - 1);
            bq.push_back(b);
        end
    endtask

    task automatic model_reset();
        bq.delete();
        m_active = 0; m_checking = 0; m_req = 0; m_wait = 0; m_end = 0; m_ovr = 0;
    endtask

    task automatic model_step();
        if (!m_active) begin
            if (frame_start) begin
                m_active = 1;
                build_frame();
                m_checking = 1;
            end
        end else begin
            if (frame_start) m_ovr = 1;
            if (m_end) begin
                m_end = 0;
`ifdef LCD_BURST_SCHED_AUTO_RESTART_EN
                build_frame();
                m_checking = 1;
`else
                m_active = 0;
`endif
            end else if (m_checking) begin
                if (bq.size() == 0) begin
                    m_checking = 0;
                    m_end = 1;
                end else if (int'(fifo_wr_cnt) + BL <= DEPTH - 1) begin
                    m_checking = 0;
                    m_req = 1;
                end
            end else if (m_req) begin
                if (burst_ack) begin
                    m_req = 0;
                    m_wait = 1;
                end
            end else if (m_wait) begin
                if (burst_done) begin
                    m_wait = 0;
                    bq.delete(0);
                    m_checking = 1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            logic [31:0] e_addr;
            logic [7:0]  e_len;
            @(negedge clk);
            if (!rst_n) model_reset();
            e_addr = (m_req && bq.size() > 0) ? bq[0].a : 32'd0;
            e_len  = (m_req && bq.size() > 0) ? bq[0].l : 8'd0;
            n_checks++;
            if ({burst_req, burst_addr, burst_len, busy, frame_done, frame_overrun} !==
                {m_req, e_addr, e_len, m_active, m_end, m_ovr}) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: dut req=%b addr=%h len=%0d busy=%b done=%b ovr=%b, model req=%b addr=%h len=%0d busy=%b done=%b ovr=%b",
                         $time, burst_req, burst_addr, burst_len, busy, frame_done, frame_overrun,
                         m_req, e_addr, e_len, m_active, m_end, m_ovr);
            end
            if (burst_req && burst_ack) begin
                burst_t b;
                b.a = burst_addr;
                b.l = burst_len;
                blog.push_back(b);
            end
            if (frame_done) n_frame_done++;
            if (rst_n) model_step();
        end
    end

    // Memory-master responder: ack/done delays are fixed (cfg >= 0) or random; optional spurious pulses.
    int ack_cfg = 0, done_cfg = 3;
    bit spur_en = 0;
    bit outstanding = 0;
    int ack_cnt = -1, done_cnt = 0;

    initial begin
        burst_ack = 0;
        burst_done = 0;
        forever begin
            @(posedge clk);
            #2;
            burst_ack = 0;
            burst_done = 0;
            if (!rst_n) begin
                outstanding = 0;
                ack_cnt = -1;
            end else if (outstanding) begin
                if (done_cnt == 0) begin
                    burst_done = 1;
                    outstanding = 0;
                end else begin
                    done_cnt--;
                end
                if (spur_en && !burst_req && $urandom_range(0, 5) == 0) burst_ack = 1;
            end else if (burst_req) begin
                if (ack_cnt < 0) ack_cnt = (ack_cfg < 0) ? int'($urandom_range(0, 4)) : ack_cfg;
                if (ack_cnt == 0) begin
                    burst_ack = 1;
                    outstanding = 1;
                    ack_cnt = -1;
                    done_cnt = (done_cfg < 0) ? int'($urandom_range(0, 6)) : done_cfg;
                end else begin
                    ack_cnt--;
                    if (spur_en && $urandom_range(0, 5) == 0) burst_done = 1;
                end
            end else if (spur_en) begin
                burst_ack  = ($urandom_range(0, 5) == 0);
                burst_done = ($urandom_range(0, 5) == 0);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        frame_start = 1;
        cyc(1);
        frame_start = 0;
    endtask

    task automatic wait_frame_done(input int budget);
        int k;
        k = 0;
        while (k < budget && frame_done !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k >= budget) begin
            n_fail++;
            $display("FAIL frame_done_wait: no pulse within %0d cycles", budget);
        end
        cyc(1);
    endtask

    task automatic wait_outstanding(input int budget);
        int k;
        k = 0;
        while (k < budget && !outstanding) begin
            cyc(1);
            k++;
        end
        n_checks++;
        if (k >= budget) begin
            n_fail++;
            $display("FAIL ack_wait: no burst accepted within %0d cycles", budget);
        end
    endtask

`ifndef LCD_BURST_SCHED_AUTO_RESTART_EN
    task automatic check_frame_bursts(input string tag);
        logic [31:0] ea [3];
        logic [7:0]  el [3];
        ea = '{32'h1000_0000, 32'h1000_0040, 32'h1000_0080};
        el = '{8'd15, 8'd15, 8'd7};
        check({tag, "_nbursts"}, blog.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            burst_t b;
            b.a = 'x;
            b.l = 'x;
            if (i < blog.size()) b = blog[i];
            check($sformatf("%s_addr%0d", tag, i), b.a, ea[i]);
            check($sformatf("%s_len%0d", tag, i), {24'd0, b.l}, {24'd0, el[i]});
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        frame_start = 0;
        fifo_wr_cnt = 0;
        cyc(3);
        check("rst_req", burst_req, 0);
        check("rst_addr", burst_addr, 0);
        check("rst_len", burst_len, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_ovr", frame_overrun, 0);
        rst_n = 1;
        cyc(2);

`ifndef LCD_BURST_SCHED_AUTO_RESTART_EN
        // Basic frame: 40 words as 16+16+8, ack after 1 cycle, done 4 cycles after ack.
        blog.delete();
        n_frame_done = 0;
        pulse_start();
        check("lat_cyc1_req", burst_req, 0);
        cyc(1);
        check("lat_cyc2_req", burst_req, 1);
        check("lat_cyc2_addr", burst_addr, BASE);
        check("lat_cyc2_len", burst_len, 15);
        wait_frame_done(200);
        check_frame_bursts("frame1");
        check("frame1_ndone", n_frame_done, 1);
        check("frame1_busy_after", busy, 0);

        // FIFO nearly full: no request until the fill level leaves room for a full burst.
        fifo_wr_cnt = 10'd1010;
        pulse_start();
        cyc(8);
        check("fifo_full_hold", burst_req, 0);
        fifo_wr_cnt = 10'd1007;
        cyc(1);
        check("fifo_room_req", burst_req, 1);
        fifo_wr_cnt = 10'd0;
        wait_frame_done(200);

        // Slow ack: request fields stay stable while waiting.
        ack_cfg = 10;
        pulse_start();
        cyc(1);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("hold_req%0d", i), burst_req, 1);
            check($sformatf("hold_addr%0d", i), burst_addr, BASE);
            check($sformatf("hold_len%0d", i), burst_len, 15);
            cyc(1);
        end
        ack_cfg = 0;
        wait_frame_done(300);

        // frame_start during WAIT: flagged, sequence untouched, flag sticky.
        blog.delete();
        pulse_start();
        wait_outstanding(50);
        pulse_start();
        check("ovr_set", frame_overrun, 1);
        wait_frame_done(200);
        check_frame_bursts("ovr_frame");
        cyc(3);
        check("ovr_sticky", frame_overrun, 1);
        check("ovr_idle_busy", busy, 0);

        // Asynchronous reset in WAIT.
        pulse_start();
        wait_outstanding(50);
        rst_n = 0;
        #1;
        check("arst_req", burst_req, 0);
        check("arst_busy", busy, 0);
        check("arst_ovr", frame_overrun, 0);
        check("arst_done", frame_done, 0);
        cyc(1);
        rst_n = 1;
        cyc(8);
        check("arst_idle_busy", busy, 0);
        blog.delete();
        pulse_start();
        wait_frame_done(200);
        check_frame_bursts("post_rst");
`else
        // Continuous refetch: single-burst frames repeat at the base address.
        blog.delete();
        n_frame_done = 0;
        pulse_start();
        cyc(1);
        check("auto_req", burst_req, 1);
        check("auto_addr", burst_addr, BASE);
        check("auto_len", burst_len, 15);
        for (int f = 0; f < 3; f++) wait_frame_done(100);
        check("auto_busy", busy, 1);
        check("auto_ndone", n_frame_done, 3);
        check("auto_nbursts_ge3", 32'(blog.size() >= 3), 1);
        foreach (blog[i]) begin
            check($sformatf("auto_baddr%0d", i), blog[i].a, BASE);
            check($sformatf("auto_blen%0d", i), {24'd0, blog[i].l}, 32'd15);
        end
`endif

        // Random phase: random delays, FIFO levels, frame starts, spurious handshakes, occasional resets.
        spur_en = 1;
        ack_cfg = -1;
        done_cfg = -1;
        for (int c = 0; c < 4000; c++) begin
            frame_start = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) fifo_wr_cnt = 10'($urandom_range(1000, 1023));
            else fifo_wr_cnt = 10'($urandom_range(0, 1009));
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 0;
                frame_start = 0;
                cyc(1);
                rst_n = 1;
            end else begin
                cyc(1);
            end
        end
        frame_start = 0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
